// File: rtl/gradient_inlet_pump_if.sv
// rtl/gradient_inlet_pump_if.sv - command and status bundle for the gradient inlet pump
interface gradient_inlet_pump_if #(
    parameter int PER_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             pause;
    logic             en_a;
    logic             en_b;
    logic [PER_W-1:0] period;
    logic [CNT_W-1:0] strokes;
    logic [2:0]       valves_a;
    logic [2:0]       valves_b;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] stroke_cnt;

    modport master (
        output start, abort, pause, en_a, en_b, period, strokes,
        input  valves_a, valves_b, busy, done, aborted, stroke_cnt
    );

    modport slave (
        input  start, abort, pause, en_a, en_b, period, strokes,
        output valves_a, valves_b, busy, done, aborted, stroke_cnt
    );
endinterface

// File: rtl/gradient_inlet_pump.sv
// rtl/gradient_inlet_pump.sv - six-phase peristaltic valve sequencer for two phase-locked gradient inlets
module gradient_inlet_pump #(
    parameter int PER_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gradient_inlet_pump_if.slave pump
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] VALVES_CLOSED = 3'b111;
    localparam logic [2:0] LAST_PHASE    = 3'd5;

    state_t           state, state_nxt;
    logic [PER_W-1:0] per_last, per_last_nxt;
    logic [PER_W-1:0] timer, timer_nxt;
    logic [2:0]       phase, phase_nxt;
    logic [CNT_W-1:0] strk, strk_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             en_a_q, en_a_nxt;
    logic             en_b_q, en_b_nxt;
    logic [2:0]       va_q, va_nxt;
    logic [2:0]       vb_q, vb_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             abt_q, abt_nxt;
    logic             active_nxt;

    function automatic logic [2:0] phase_pattern(input logic [2:0] p);
        case (p)
            3'd0:    phase_pattern = 3'b101;
            3'd1:    phase_pattern = 3'b100;
            3'd2:    phase_pattern = 3'b110;
            3'd3:    phase_pattern = 3'b010;
            3'd4:    phase_pattern = 3'b011;
            3'd5:    phase_pattern = 3'b001;
            default: phase_pattern = VALVES_CLOSED;
        endcase
    endfunction

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt    = state;
        per_last_nxt = per_last;
        timer_nxt    = timer;
        phase_nxt    = phase;
        strk_nxt     = strk;
        cnt_nxt      = cnt;
        en_a_nxt     = en_a_q;
        en_b_nxt     = en_b_q;
        done_nxt     = 1'b0;
        abt_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (pump.start && !pump.abort) begin
                    en_a_nxt     = pump.en_a;
                    en_b_nxt     = pump.en_b;
                    // Store period-1 so a zero period naturally behaves as one cycle.
                    per_last_nxt = (pump.period == '0) ? '0 : pump.period - 1'b1;
                    strk_nxt     = pump.strokes;
                    cnt_nxt      = '0;
                    timer_nxt    = '0;
                    phase_nxt    = '0;
                    if (pump.strokes == '0) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end

            S_RUN, S_HOLD: begin
                if (pump.abort) begin
                    state_nxt = S_IDLE;
                    abt_nxt   = 1'b1;
                end else if (pump.pause) begin
                    state_nxt = S_HOLD;
                end else begin
                    // Leaving HOLD consumes a timer tick on the same edge, so a
                    // pause of N cycles stretches the phase by exactly N.
                    state_nxt = S_RUN;
                    if (timer == per_last) begin
                        timer_nxt = '0;
                        if (phase == LAST_PHASE) begin
                            phase_nxt = '0;
                            cnt_nxt   = cnt_inc;
                            if (cnt_inc == strk) begin
                                state_nxt = S_DONE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            phase_nxt = phase + 3'd1;
                        end
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        active_nxt = (state_nxt == S_RUN) || (state_nxt == S_HOLD);
        busy_nxt   = active_nxt;
        va_nxt     = (active_nxt && en_a_nxt) ? phase_pattern(phase_nxt) : VALVES_CLOSED;
        vb_nxt     = (active_nxt && en_b_nxt) ? phase_pattern(phase_nxt) : VALVES_CLOSED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            per_last <= '0;
            timer    <= '0;
            phase    <= '0;
            strk     <= '0;
            cnt      <= '0;
            en_a_q   <= 1'b0;
            en_b_q   <= 1'b0;
            va_q     <= VALVES_CLOSED;
            vb_q     <= VALVES_CLOSED;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abt_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            per_last <= per_last_nxt;
            timer    <= timer_nxt;
            phase    <= phase_nxt;
            strk     <= strk_nxt;
            cnt      <= cnt_nxt;
            en_a_q   <= en_a_nxt;
            en_b_q   <= en_b_nxt;
            va_q     <= va_nxt;
            vb_q     <= vb_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            abt_q    <= abt_nxt;
        end
    end

    assign pump.valves_a   = va_q;
    assign pump.valves_b   = vb_q;
    assign pump.busy       = busy_q;
    assign pump.done       = done_q;
    assign pump.aborted    = abt_q;
    assign pump.stroke_cnt = cnt;

endmodule

// File: tb/tb_gradient_inlet_pump.sv
// tb/tb_gradient_inlet_pump.sv - directed bench with elapsed-time reference model for gradient_inlet_pump
module tb_gradient_inlet_pump;

    localparam int PER_W = 16;
    localparam int CNT_W = 16;
    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gradient_inlet_pump_if #(.PER_W(PER_W), .CNT_W(CNT_W)) bus ();

    gradient_inlet_pump #(.PER_W(PER_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .pump (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;
    int busy_cycles = 0;
    int done_cnt = 0;
    int abt_cnt = 0;
    int vb_open = 0;
    logic [2:0] seq [64];
    logic [2:0] pat [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [2:0] exp_seq [12] = '{3'b101, 3'b101, 3'b100, 3'b100, 3'b110, 3'b110,
                                 3'b010, 3'b010, 3'b011, 3'b011, 3'b001, 3'b001};

    // Reference model: tracks only elapsed active cycles since start; phase and
    // stroke are derived from that time by division.
    int             m_mode = M_IDLE;
    longint         m_t = 0;
    longint         m_per = 1;
    longint         m_strk = 0;
    logic           m_ena = 1'b0;
    logic           m_enb = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic           m_done = 1'b0;
    logic           m_abt = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_IDLE;
            m_t    <= 0;
            m_cnt  <= '0;
            m_done <= 1'b0;
            m_abt  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_abt  <= 1'b0;
            if (m_mode == M_IDLE) begin
                if (bus.start && !bus.abort) begin
                    m_per  <= (bus.period == 0) ? 1 : longint'(bus.period);
                    m_strk <= longint'(bus.strokes);
                    m_ena  <= bus.en_a;
                    m_enb  <= bus.en_b;
                    m_t    <= 0;
                    m_cnt  <= '0;
                    if (bus.strokes == 0) begin
                        m_mode <= M_DONE;
                        m_done <= 1'b1;
                    end else begin
                        m_mode <= M_ACT;
                    end
                end
            end else if (m_mode == M_ACT) begin
                if (bus.abort) begin
                    m_mode <= M_IDLE;
                    m_abt  <= 1'b1;
                end else if (!bus.pause) begin
                    m_t <= m_t + 1;
                    if (m_t + 1 == 6 * m_per * m_strk) begin
                        m_mode <= M_DONE;
                        m_done <= 1'b1;
                        m_cnt  <= CNT_W'(m_strk);
                    end else begin
                        m_cnt <= CNT_W'((m_t + 1) / (6 * m_per));
                    end
                end
            end else begin
                m_mode <= M_IDLE;
            end
        end
    end

    function automatic logic [2:0] exp_valves(input logic en);
        if (m_mode != M_ACT || !en) return 3'b111;
        return pat[int'((m_t / m_per) % 6)];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("busy", bus.busy, m_mode == M_ACT);
            chk("done", bus.done, m_done);
            chk("aborted", bus.aborted, m_abt);
            chk("stroke_cnt", bus.stroke_cnt, m_cnt);
            chk("valves_a", bus.valves_a, exp_valves(m_ena));
            chk("valves_b", bus.valves_b, exp_valves(m_enb));
            if (bus.busy) begin
                seq[busy_cycles % 64] = bus.valves_a;
                busy_cycles++;
            end
            if (bus.done) done_cnt++;
            if (bus.aborted) abt_cnt++;
            if (bus.valves_b != 3'b111) vb_open++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic ea, input logic eb, input int per, input int strk);
        bus.en_a    = ea;
        bus.en_b    = eb;
        bus.period  = PER_W'(per);
        bus.strokes = CNT_W'(strk);
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        for (int i = 0; i < limit && done_cnt == d0; i++) step();
        chk("done_within_bound", done_cnt > d0, 1);
    endtask

    int b0, d0, a0, v0;

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        bus.en_a = 1'b0; bus.en_b = 1'b0; bus.period = '0; bus.strokes = '0;
        fork
            compare_loop();
        join_none
        #1 rst = 1'b1;
        repeat (2) step();
        chk("reset_valves_a", bus.valves_a, 3'b111);
        chk("reset_valves_b", bus.valves_b, 3'b111);
        chk("reset_busy", bus.busy, 0);
        chk("reset_stroke_cnt", bus.stroke_cnt, 0);
        rst = 1'b0;
        step();

        // Basic run: both inlets, 2 cycles per phase, one stroke
        b0 = busy_cycles; d0 = done_cnt;
        start_run(1'b1, 1'b1, 2, 1);
        wait_done(d0, 40);
        step();
        chk("basic_busy_cycles", busy_cycles - b0, 12);
        chk("basic_done_pulses", done_cnt - d0, 1);
        chk("basic_stroke_cnt", bus.stroke_cnt, 1);
        chk("basic_idle_valves", bus.valves_a, 3'b111);
        for (int i = 0; i < 12; i++) chk("basic_phase_seq", seq[(b0 + i) % 64], exp_seq[i]);

        // Single inlet, zero period, inputs changed mid-run must be ignored
        b0 = busy_cycles; d0 = done_cnt; v0 = vb_open;
        start_run(1'b1, 1'b0, 0, 3);
        bus.period = 16'd5; bus.en_b = 1'b1; bus.strokes = 16'd1;
        wait_done(d0, 60);
        step();
        chk("zero_per_busy_cycles", busy_cycles - b0, 18);
        chk("zero_per_stroke_cnt", bus.stroke_cnt, 3);
        chk("zero_per_valves_b_open", vb_open - v0, 0);

        // Pause for 5 cycles inside P2
        b0 = busy_cycles; d0 = done_cnt;
        start_run(1'b1, 1'b1, 4, 1);
        repeat (9) step();
        chk("pause_in_p2", bus.valves_a, 3'b110);
        bus.pause = 1'b1;
        repeat (5) step();
        chk("pause_frozen_p2", bus.valves_a, 3'b110);
        bus.pause = 1'b0;
        wait_done(d0, 60);
        step();
        chk("pause_busy_cycles", busy_cycles - b0, 29);
        chk("pause_done_pulses", done_cnt - d0, 1);

        // Abort during stroke 3, then start and abort together in IDLE
        d0 = done_cnt; a0 = abt_cnt;
        start_run(1'b1, 1'b1, 1, 10);
        repeat (14) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_pulse", bus.aborted, 1);
        chk("abort_stroke_cnt", bus.stroke_cnt, 2);
        chk("abort_valves", bus.valves_b, 3'b111);
        step();
        chk("abort_pulse_one_cycle", bus.aborted, 0);
        bus.abort = 1'b1;
        start_run(1'b1, 1'b1, 1, 5);
        bus.abort = 1'b0;
        chk("start_abort_idle", bus.busy, 0);
        step();
        chk("start_abort_idle_later", bus.busy, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_pulse_count", abt_cnt - a0, 1);

        // Zero strokes completes immediately without running
        b0 = busy_cycles; d0 = done_cnt;
        start_run(1'b1, 1'b1, 3, 0);
        chk("zero_strokes_done", bus.done, 1);
        chk("zero_strokes_valves", bus.valves_a, 3'b111);
        step();
        chk("zero_strokes_done_one_cycle", bus.done, 0);
        step();
        chk("zero_strokes_busy_cycles", busy_cycles - b0, 0);
        chk("zero_strokes_done_pulses", done_cnt - d0, 1);

        // Asynchronous reset in P3 of stroke 2
        start_run(1'b1, 1'b1, 2, 3);
        repeat (19) step();
        chk("pre_reset_p3", bus.valves_a, 3'b010);
        chk("pre_reset_stroke_cnt", bus.stroke_cnt, 1);
        d0 = done_cnt; a0 = abt_cnt;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valves_a", bus.valves_a, 3'b111);
        chk("async_rst_valves_b", bus.valves_b, 3'b111);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_stroke_cnt", bus.stroke_cnt, 0);
        chk("async_rst_done", bus.done, 0);
        chk("async_rst_aborted", bus.aborted, 0);
        step();
        rst = 1'b0;
        b0 = busy_cycles;
        repeat (30) step();
        chk("post_reset_idle_busy", busy_cycles - b0, 0);
        chk("post_reset_no_done", done_cnt - d0, 0);
        chk("post_reset_no_abort", abt_cnt - a0, 0);

        // Fresh start after reset, inlet B only
        b0 = busy_cycles; d0 = done_cnt;
        start_run(1'b0, 1'b1, 1, 1);
        wait_done(d0, 20);
        step();
        chk("restart_busy_cycles", busy_cycles - b0, 6);
        chk("restart_stroke_cnt", bus.stroke_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
